esc_host_framer: RTL
====================

Name: esc_host_framer

Overview:
- Host-side endpoint of the ESC-framed debug UART byte protocol; the initiator that talks to the target's escape filter.
- Frames one request per transaction: ESC + command byte, then an ESC-stuffed payload. Pushes the bytes into a UART TX FIFO.
- Then collects and de-stuffs the response bytes from a UART RX FIFO.
- Used for on-chip loopback self-test and FPGA bring-up of the debug UART path.

Parameters:
- ESC, 8'hB1, escape byte; must match the target side.
- NBYTES, 4, maximum payload bytes per direction (1..8).
- TIMEOUT, 65535, idle-cycle limit in the receive phase (used only with HOST_TIMEOUT_EN).

Ports:
- CLK_I  in  1  clock
- RST_NI  in  1  reset; asynchronous, active-low
- REQ_VALID_I  in  1  request valid
- REQ_READY_O  out  1  framer idle, request can be accepted
- REQ_CMD_I  in  8  command byte; must not equal ESC
- REQ_DATA_I  in  8*NBYTES  payload to send, byte 0 = [7:0]
- REQ_NTX_I  in  4  payload bytes to send (clamped to NBYTES)
- REQ_NRX_I  in  4  response bytes expected (clamped to NBYTES)
- RSP_VALID_O  out  1  response valid
- RSP_READY_I  in  1  response consumed
- RSP_DATA_O  out  8*NBYTES  received payload, byte 0 = [7:0]
- RSP_STATUS_O  out  2  00 ok, 01 unexpected command, 10 timeout
- RSP_CMD_O  out  8  command byte received when status = 01
- TX_READY_I  in  1  TX FIFO not full
- WRITE_O  out  1  push DATA_SEND_O into TX FIFO
- DATA_SEND_O  out  8  byte to transmit
- RX_EMPTY_I  in  1  RX FIFO empty
- DATA_REC_I  in  8  RX FIFO head byte (first-word fall-through); valid while RX_EMPTY_I = 0
- READ_O  out  1  pop RX FIFO head

Behaviour:
- Reset: state IDLE; REQ_READY_O = 1; all other outputs 0; byte counters 0.
- Reset mid-operation aborts at once. Any partially sent frame is not completed. The FIFOs are not flushed.
- FSM states: IDLE, TX_ESC, TX_CMD, TX_DATA, TX_STUFF, RX_DATA, RX_ESC, DONE.
- IDLE:
  - REQ_READY_O = 1.
  - On REQ_VALID_I & REQ_READY_O: latch cmd, data, clamped NTX and NRX; clear RSP_DATA_O, RSP_STATUS_O and RSP_CMD_O; go to TX_ESC.
- Send states:
  - WRITE_O = TX_READY_I. A byte is accepted in the same cycle WRITE_O is high; the state advances only on acceptance.
  - While TX_READY_I = 0 the FSM holds, DATA_SEND_O stays stable and WRITE_O stays 0.
  - TX_ESC: DATA_SEND_O = ESC. Next state TX_CMD.
  - TX_CMD: DATA_SEND_O = cmd. Next state TX_DATA if NTX > 0, else RX_DATA.
  - TX_DATA: DATA_SEND_O = byte[tx_cnt]. If that byte == ESC, go to TX_STUFF without incrementing. Otherwise increment tx_cnt; at tx_cnt == NTX go to RX_DATA.
  - TX_STUFF: DATA_SEND_O = ESC. Increment tx_cnt, then apply the same exit rule as TX_DATA.
- Entry to RX_DATA with NRX = 0 goes straight to DONE; no byte is read.
- RX_DATA:
  - READ_O = ~RX_EMPTY_I.
  - Popped byte != ESC: store it at index rx_cnt and increment rx_cnt. At rx_cnt == NRX go to DONE.
  - Popped byte == ESC: go to RX_ESC; nothing is stored.
- RX_ESC:
  - READ_O = ~RX_EMPTY_I.
  - Popped byte == ESC: store ESC as data, then apply the same rule as RX_DATA.
  - Popped byte is anything else: latch it into RSP_CMD_O, set status 01, go to DONE.
- DONE:
  - RSP_VALID_O = 1; RSP_DATA_O, RSP_STATUS_O and RSP_CMD_O are stable.
  - Holds until RSP_READY_I = 1, then goes to IDLE.
  - Bytes not received stay 0.
- Latency, no backpressure, no stuffing: request accept to first WRITE_O is 1 cycle. The last RX pop to RSP_VALID_O is 1 cycle.
- Throughput: one TX byte per cycle; one RX byte per cycle.
- Counters are 4 bits wide. Clamping guarantees tx_cnt and rx_cnt never exceed NBYTES, so there is no wrap-around.
- REQ_CMD_I == ESC is illegal. The framer sends it unchanged; the bench must not drive it.

Optional Feature:
- Macro HOST_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter runs in RX_DATA and RX_ESC. It clears on every pop.
  - On reaching TIMEOUT it sets status 10 and goes to DONE, keeping any bytes already received.
- Undefined:
  - No counter; the framer waits indefinitely in the receive phase.
  - Status 10 never occurs.

Test Plan:
1. cmd 0x02, NTX 2, data 0x3412, NRX 0, TX_READY_I = 1 -> TX bytes B1,02,12,34 on 4 consecutive cycles; RSP_VALID_O with status 00.
2. NTX 3, data 0x00B155 -> TX bytes B1,cmd,55,B1,B1,00. Toggle TX_READY_I every cycle -> same byte sequence and DATA_SEND_O held stable while stalled.
3. NRX 4, RX bytes 11,B1,B1,22,33 -> RSP_DATA_O = 0x33_22_B1_11, status 00; READ_O high exactly 5 cycles.
4. NRX 4, RX bytes 11,B1,07 -> status 01, RSP_CMD_O = 0x07, RSP_DATA_O = 0x00000011.
5. Hold RSP_READY_I = 0 for 10 cycles in DONE -> outputs stable, REQ_READY_O = 0. Then pulse RSP_READY_I -> IDLE.
6. Assert RST_NI low mid-TX_DATA -> next cycle WRITE_O = 0, REQ_READY_O = 1. With HOST_TIMEOUT_EN and TIMEOUT = 20, NRX 2 with one byte then silence -> status 10 after 20 idle cycles.

Source files
------------

// File: rtl/esc_host_framer.sv
//------------------------------------------------------------------------------
// esc_host_framer
//   Host-side initiator for the ESC-framed debug UART byte protocol. Each
//   request is framed as ESC + command byte followed by an ESC-stuffed payload
//   and pushed into a UART TX FIFO. The response is then popped from a UART RX
//   FIFO and de-stuffed into a parallel response word.
//
//   Optional feature macro: HOST_TIMEOUT_EN
//     defined   : a 16-bit idle counter aborts the receive phase with status 10
//                 after TIMEOUT cycles without a pop
//     undefined : the receive phase waits indefinitely
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o     request handshake
//   req_cmd_i, req_data_i         command byte and payload (byte 0 = [7:0])
//   req_ntx_i, req_nrx_i          payload bytes to send / expect (clamped)
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_data_o, rsp_status_o,     received payload, status (00 ok,
//   rsp_cmd_o                     01 unexpected command, 10 timeout), command
//   tx_ready_i, write_o,          TX FIFO push interface
//   data_send_o
//   rx_empty_i, data_rec_i,       RX FIFO (first-word fall-through) pop
//   read_o                        interface
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module esc_host_framer #(
  parameter logic [7:0] ESC     = 8'hB1,
  parameter int         NBYTES  = 4,
  parameter int         TIMEOUT = 65535
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [7:0]            req_cmd_i,
  input  logic [8*NBYTES-1:0]   req_data_i,
  input  logic [3:0]            req_ntx_i,
  input  logic [3:0]            req_nrx_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [8*NBYTES-1:0]   rsp_data_o,
  output logic [1:0]            rsp_status_o,
  output logic [7:0]            rsp_cmd_o,
  input  logic                  tx_ready_i,
  output logic                  write_o,
  output logic [7:0]            data_send_o,
  input  logic                  rx_empty_i,
  input  logic [7:0]            data_rec_i,
  output logic                  read_o
);

  localparam logic [3:0] NB = 4'(NBYTES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_ESC   = 3'd1,
    TX_CMD   = 3'd2,
    TX_DATA  = 3'd3,
    TX_STUFF = 3'd4,
    RX_DATA  = 3'd5,
    RX_ESC   = 3'd6,
    DONE     = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [8*NBYTES-1:0]   data_q, data_d;
  logic [3:0]            ntx_q, ntx_d;
  logic [3:0]            nrx_q, nrx_d;
  logic [3:0]            tx_cnt_q, tx_cnt_d;
  logic [3:0]            rx_cnt_q, rx_cnt_d;
  logic [8*NBYTES-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic [7:0]            rsp_cmd_q, rsp_cmd_d;

  logic [7:0]            tx_byte;
  logic [3:0]            tx_inc;
  logic [3:0]            rx_inc;
  state_e                rx_entry;
  state_e                tx_exit;
  state_e                rx_exit;
  logic [8*NBYTES-1:0]   rsp_data_store;

`ifdef HOST_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);
  logic [15:0]           idle_q, idle_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // Payload byte selected by tx_cnt; constant-index mux keeps index widths clean.
  always_comb begin
    tx_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (tx_cnt_q == 4'(i)) tx_byte = data_q[i*8 +: 8];
    end
  end

  // Response word with the current RX byte written at rx_cnt.
  always_comb begin
    rsp_data_store = rsp_data_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (rx_cnt_q == 4'(i)) rsp_data_store[i*8 +: 8] = data_rec_i;
    end
  end

  assign tx_inc   = tx_cnt_q + 4'd1;
  assign rx_inc   = rx_cnt_q + 4'd1;
  // Entering the receive phase with nothing to receive skips straight to DONE.
  assign rx_entry = (nrx_q == 4'd0) ? DONE : RX_DATA;
  assign tx_exit  = (tx_inc == ntx_q) ? rx_entry : TX_DATA;
  assign rx_exit  = (rx_inc == nrx_q) ? DONE : RX_DATA;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    ntx_d        = ntx_q;
    nrx_d        = nrx_q;
    tx_cnt_d     = tx_cnt_q;
    rx_cnt_d     = rx_cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    rsp_cmd_d    = rsp_cmd_q;
`ifdef HOST_TIMEOUT_EN
    idle_d       = idle_q;
`endif
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    write_o      = 1'b0;
    data_send_o  = 8'h00;
    read_o       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          cmd_d        = req_cmd_i;
          data_d       = req_data_i;
          ntx_d        = (req_ntx_i > NB) ? NB : req_ntx_i;
          nrx_d        = (req_nrx_i > NB) ? NB : req_nrx_i;
          tx_cnt_d     = 4'd0;
          rx_cnt_d     = 4'd0;
          rsp_data_d   = '0;
          rsp_status_d = 2'b00;
          rsp_cmd_d    = 8'h00;
          state_d      = TX_ESC;
        end
      end

      TX_ESC: begin
        data_send_o = ESC;
        write_o     = tx_ready_i;
        if (tx_ready_i) state_d = TX_CMD;
      end

      TX_CMD: begin
        data_send_o = cmd_q;
        write_o     = tx_ready_i;
        if (tx_ready_i) state_d = (ntx_q == 4'd0) ? rx_entry : TX_DATA;
      end

      TX_DATA: begin
        data_send_o = tx_byte;
        write_o     = tx_ready_i;
        if (tx_ready_i) begin
          // An ESC payload byte is followed by a second ESC before advancing.
          if (tx_byte == ESC) begin
            state_d = TX_STUFF;
          end else begin
            tx_cnt_d = tx_inc;
            state_d  = tx_exit;
          end
        end
      end

      TX_STUFF: begin
        data_send_o = ESC;
        write_o     = tx_ready_i;
        if (tx_ready_i) begin
          tx_cnt_d = tx_inc;
          state_d  = tx_exit;
        end
      end

      RX_DATA: begin
        read_o = ~rx_empty_i;
        if (!rx_empty_i) begin
          if (data_rec_i == ESC) begin
            state_d = RX_ESC;
          end else begin
            rsp_data_d = rsp_data_store;
            rx_cnt_d   = rx_inc;
            state_d    = rx_exit;
          end
        end
      end

      RX_ESC: begin
        read_o = ~rx_empty_i;
        if (!rx_empty_i) begin
          if (data_rec_i == ESC) begin
            rsp_data_d = rsp_data_store;
            rx_cnt_d   = rx_inc;
            state_d    = rx_exit;
          end else begin
            rsp_cmd_d    = data_rec_i;
            rsp_status_d = 2'b01;
            state_d      = DONE;
          end
        end
      end

      DONE: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

`ifdef HOST_TIMEOUT_EN
    // Idle counter only advances on receive-phase cycles without a pop.
    if ((state_q == RX_DATA) || (state_q == RX_ESC)) begin
      if (rx_empty_i) begin
        if (idle_q == TO_LIM - 16'd1) begin
          idle_d       = 16'd0;
          rsp_status_d = 2'b10;
          state_d      = DONE;
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end else begin
        idle_d = 16'd0;
      end
    end else begin
      idle_d = 16'd0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cmd_q        <= 8'h00;
      data_q       <= '0;
      ntx_q        <= 4'd0;
      nrx_q        <= 4'd0;
      tx_cnt_q     <= 4'd0;
      rx_cnt_q     <= 4'd0;
      rsp_data_q   <= '0;
      rsp_status_q <= 2'b00;
      rsp_cmd_q    <= 8'h00;
`ifdef HOST_TIMEOUT_EN
      idle_q       <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      ntx_q        <= ntx_d;
      nrx_q        <= nrx_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      rsp_cmd_q    <= rsp_cmd_d;
`ifdef HOST_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign rsp_data_o   = rsp_data_q;
  assign rsp_status_o = rsp_status_q;
  assign rsp_cmd_o    = rsp_cmd_q;

endmodule

`default_nettype wire
